// File: rtl/par_sng.sv
// Parallel stochastic number generator: turns one binary value into a 2^WIDTH-bit
// unary bitstream, LANES bits per beat, whose popcount reproduces the saturated value.
module par_sng #(
    parameter int WIDTH = 4,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   value,
    output logic [LANES-1:0] bits_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last
);

    localparam int NBEATS = (1 << WIDTH) / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [WIDTH:0] FULL      = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [WIDTH:0]  value_q;
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_d;

    function automatic logic [WIDTH:0] sat(input logic [WIDTH:0] v);
        return (v > FULL) ? FULL : v;
    endfunction

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) begin
            r[k] = x[WIDTH-1-k];
        end
        return r;
    endfunction

    assign beat_d = beat_q + BW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            value_q <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        value_q <= sat(value);
                        beat_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // The counter stops at the last beat, so it never wraps.
                    if (out_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign last      = (state_q == RUN) && (beat_q == LAST_BEAT);

    // Bit-reversed thresholds spread the ones evenly across beats and lanes.
    always_comb begin
        logic [WIDTH-1:0] idx;
        bits_out = '0;
        idx      = '0;
        if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                idx         = WIDTH'(int'(beat_q) * LANES + l);
                bits_out[l] = (value_q > {1'b0, bitrev(idx)});
            end
        end
    end

endmodule

// File: tb/tb_par_sng.sv
// Bench for par_sng (WIDTH=4, LANES=4): table-driven streams checked beat by beat
// through a scoreboard, plus backpressure, saturation, mid-stream reset and a full sweep.
module tb_par_sng;

    localparam int WIDTH = 4;
    localparam int LANES = 4;
    localparam int NB    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   value;
    logic [LANES-1:0] bits_out;
    logic             out_valid;
    logic             out_ready;
    logic             last;

    always #5 clk = ~clk;

    par_sng #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .bits_out  (bits_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last)
    );

    typedef struct {
        logic [WIDTH:0]   value;
        logic [LANES-1:0] exp [NB];
    } vec_t;

    typedef struct {
        logic [LANES-1:0] bits;
        logic             last;
        logic             chk;
        int               cnt;
    } beat_t;

    beat_t sbq[$];
    int    checks      = 0;
    int    failures    = 0;
    int    acc         = 0;
    int    hs          = 0;
    logic  expect_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WIDTH:0] v, input logic [3:0] b0,
                                input logic [3:0] b1, input logic [3:0] b2, input logic [3:0] b3);
        vec_t t;
        t.value  = v;
        t.exp[0] = b0;
        t.exp[1] = b1;
        t.exp[2] = b2;
        t.exp[3] = b3;
        return t;
    endfunction

    // Monitor: compares every valid beat (held or handshaken) against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (expect_idle) begin
                check("idle_after_last_out_valid", 32'(out_valid), 0);
                check("idle_after_last_in_ready", 32'(in_ready), 1);
                expect_idle = 1'b0;
            end else if (out_valid) begin
                check("in_ready_low_in_run", 32'(in_ready), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got bits %b expected no beat", bits_out);
                end else begin
                    if (sbq[0].chk) check("bits_out", 32'(bits_out), 32'(sbq[0].bits));
                    check("last", 32'(last), 32'(sbq[0].last));
                    if (out_ready) begin
                        acc += $countones(bits_out);
                        hs++;
                        if (sbq[0].last) begin
                            check("popcount", acc, sbq[0].cnt);
                            acc = 0;
                            expect_idle = 1'b1;
                        end
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input vec_t t, input logic chk);
        int n;
        int s;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            in_valid = 1'b1;
            value    = t.value;
            @(posedge clk);
            s = (int'(t.value) > 16) ? 16 : int'(t.value);
            for (int b = 0; b < NB; b++) begin
                sbq.push_back('{bits: t.exp[b], last: (b == NB - 1), chk: chk, cnt: s});
            end
            #1;
            in_valid = 1'b0;
            value    = '0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout: got %0d pending beats expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t v5, v8, v16, v20, sw;
        logic pat[7];
        int   hs0;

        tbl[0] = mk(5'd5,  4'b0101, 4'b0001, 4'b0001, 4'b0001);
        tbl[1] = mk(5'd8,  4'b0101, 4'b0101, 4'b0101, 4'b0101);
        tbl[2] = mk(5'd0,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[3] = mk(5'd1,  4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tbl[4] = mk(5'd15, 4'b1111, 4'b1111, 4'b1111, 4'b0111);
        v5  = tbl[0];
        v8  = tbl[1];
        v16 = mk(5'd16, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        v20 = mk(5'd20, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst       = 1'b0;
        in_valid  = 1'b0;
        value     = '0;
        out_ready = 1'b1;
        #2;
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_bits_out", 32'(bits_out), 0);
        check("reset_last", 32'(last), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 32'(in_ready), 1);
        check("post_reset_out_valid", 32'(out_valid), 0);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i], 1'b1);
            wait_done();
        end

        // Saturation, with a value offered during RUN that must be ignored.
        send(v16, 1'b1);
        in_valid = 1'b1;
        value    = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        value    = '0;
        wait_done();
        @(posedge clk);
        #1;
        check("ignored_value_no_stream", 32'(out_valid), 0);
        send(v20, 1'b1);
        wait_done();

        // Backpressure.
        send(v5, 1'b1);
        hs0 = hs;
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check("backpressure_handshakes", hs - hs0, 4);
        wait_done();

        // Asynchronous reset in the middle of a stream.
        send(v8, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_bits_out", 32'(bits_out), 0);
        check("abort_last", 32'(last), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        sbq.delete();
        acc         = 0;
        expect_idle = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_abort_in_ready", 32'(in_ready), 1);
        check("after_abort_out_valid", 32'(out_valid), 0);
        send(v5, 1'b1);
        wait_done();

        // Accumulator sweep: popcount of each full stream must equal sat(value).
        for (int v = 0; v < 18; v++) begin
            sw = mk(5'(v), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            send(sw, 1'b0);
            wait_done();
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
